branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
Fetch-side predictor paired with the EX-stage branch resolution logic. IF queries it with the fetch PC and gets a taken/not-taken guess and a target. EX returns the resolved outcome (PCSrc and target), which trains a direct-mapped table of 2-bit saturating counters with a tagged target buffer. The block flags mispredictions and supplies the redirect PC.

Parameters:
ENTRIES, 16, table depth; power of two, at least 4; IDX_W = log2(ENTRIES)
TAG_W, 8, stored PC tag bits; IDX_W+2+TAG_W must be 32 or less
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
if_pc  in  32  fetch PC, word aligned
pred_hit  out  1  lookup hit: valid entry with matching tag
pred_taken  out  1  predicted taken
pred_target  out  32  predicted next PC
ex_valid  in  1  EX slot holds a live (unflushed) instruction
ex_is_branch  in  1  EX instruction is a conditional branch
ex_pc  in  32  PC of the EX instruction
ex_taken  in  1  resolved outcome (PCSrc from the branch unit)
ex_target  in  32  resolved branch target
ex_pred_taken  in  1  prediction carried down the pipe with this instruction
ex_pred_target  in  32  predicted target carried down the pipe
mispredict  out  1  flush request for the IF/ID stages
redirect_pc  out  32  correct next PC, meaningful when mispredict=1
branch_count  out  CNT_W  number of resolved branches
mispredict_count  out  CNT_W  number of mispredictions

Behaviour:
- Entry fields: valid, tag, target[31:0], ctr[1:0]. idx = pc[IDX_W+1:2]. tag = pc[IDX_W+2+TAG_W-1:IDX_W+2].
- Reset (async, rst_n=0): every valid=0, every ctr=2'b01, both perf counters=0. Target and tag values are don't-care.
- Lookup is combinational from the registered table, with zero-cycle latency:
  - pred_hit = valid & tag match.
  - pred_taken = pred_hit & ctr[1].
  - pred_target = pred_taken ? target : if_pc+4, computed mod 2^32.
- Update condition: upd = ex_valid & ex_is_branch. The write happens at the rising edge. Let ex_hit be the lookup at ex_pc.
  - ex_hit & ex_taken: ctr saturating increment (11 stays 11); target <= ex_target.
  - ex_hit & !ex_taken: ctr saturating decrement (00 stays 00); target unchanged.
  - !ex_hit & ex_taken: allocate; valid=1, tag, target=ex_target, ctr=2'b10. This replaces any previous occupant.
  - !ex_hit & !ex_taken: no change.
- Alias cleanup: when ex_valid & !ex_is_branch & ex_pred_taken and the EX index hits, that entry's valid is cleared.
- Read during write: if IF and EX address the same index in one cycle, IF sees the pre-write contents. There is no bypass.
- Mispredict is combinational:
  - Branch case: ex_valid & ex_is_branch & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_target != ex_target)).
  - Non-branch case: ex_valid & !ex_is_branch & ex_pred_taken.
- redirect_pc = (ex_is_branch & ex_taken) ? ex_target : ex_pc+4.
- ex_valid=0 means no update, mispredict=0, and no counter change.
- Perf counters step at the rising edge and saturate at all-ones, never wrapping:
  - branch_count += 1 on upd.
  - mispredict_count += 1 when mispredict=1.
- If reset asserts mid-operation, any pending write is discarded and the whole state returns to reset values immediately.

Test Plan:
- Reset, then if_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104. Both counters read 0.
- Taken branch at ex_pc=0x100, ex_target=0x80, ex_pred_taken=0 -> mispredict=1 and redirect_pc=0x80. Next cycle if_pc=0x100 gives hit=1, taken=1 (ctr=10), target=0x80. branch_count=1, mispredict_count=1.
- Same branch resolved not-taken twice -> ctr goes 10, 01, 00. Lookup at 0x100 gives taken=0 and target 0x104. The first of these resolutions reports mispredict=1 with redirect_pc=0x104. A third not-taken keeps ctr=00.
- Hit entry with target 0x80, resolved taken to 0x200 with ex_pred_taken=1, ex_pred_target=0x80 -> mispredict=1, redirect_pc=0x200, stored target becomes 0x200.
- Aliasing: ENTRIES=16, PCs 0x100 and 0x140 share an index but differ in tag. Allocate 0x100 then resolve 0x140 taken -> 0x100 misses and 0x140 hits. Separately, a non-branch at an aliasing PC with ex_pred_taken=1 -> mispredict=1, redirect_pc=ex_pc+4, entry invalidated.
- Same-cycle IF read and EX write to the same index -> IF shows old data and the following cycle shows new data. Assert rst_n low mid-stream -> all outputs return to reset values without waiting for a clock edge. Counter saturation: with CNT_W=4, 20 mispredicts hold mispredict_count at 15.

Source files
------------

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup, EX resolution and perf-counter signals of the branch predictor
interface branch_predictor_if #(parameter int CNT_W = 32);
  logic [31:0] if_pc;
  logic pred_hit;
  logic pred_taken;
  logic [31:0] pred_target;
  logic ex_valid;
  logic ex_is_branch;
  logic [31:0] ex_pc;
  logic ex_taken;
  logic [31:0] ex_target;
  logic ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic mispredict;
  logic [31:0] redirect_pc;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;
  modport master (
    output if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
    input pred_hit, pred_taken, pred_target, mispredict, redirect_pc, branch_count, mispredict_count
  );
  modport slave (
    input if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
    output pred_hit, pred_taken, pred_target, mispredict, redirect_pc, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped 2-bit counter table with tagged targets, trained from EX resolution
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int TAG_W = 8,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic rst_n,
  branch_predictor_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  logic valid [ENTRIES];
  logic [TAG_W-1:0] tags [ENTRIES];
  logic [31:0] tgts [ENTRIES];
  logic [1:0] ctrs [ENTRIES];
  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic ex_hit, upd, misp;
  logic [CNT_W-1:0] br_cnt, mp_cnt;
  assign if_idx = bp.if_pc[IDX_W+1:2];
  assign if_tag = bp.if_pc[IDX_W+2+TAG_W-1:IDX_W+2];
  assign ex_idx = bp.ex_pc[IDX_W+1:2];
  assign ex_tag = bp.ex_pc[IDX_W+2+TAG_W-1:IDX_W+2];
  assign bp.pred_hit = valid[if_idx] && tags[if_idx] == if_tag;
  assign bp.pred_taken = bp.pred_hit && ctrs[if_idx][1];
  assign bp.pred_target = bp.pred_taken ? tgts[if_idx] : bp.if_pc + 32'd4;
  assign ex_hit = valid[ex_idx] && tags[ex_idx] == ex_tag;
  assign upd = bp.ex_valid && bp.ex_is_branch;
  assign misp = upd ? (bp.ex_taken != bp.ex_pred_taken) || (bp.ex_taken && bp.ex_pred_target != bp.ex_target)
                    : bp.ex_valid && bp.ex_pred_taken;
  assign bp.mispredict = misp;
  assign bp.redirect_pc = (bp.ex_is_branch && bp.ex_taken) ? bp.ex_target : bp.ex_pc + 32'd4;
  assign bp.branch_count = br_cnt;
  assign bp.mispredict_count = mp_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i] <= 1'b0;
        tags[i] <= '0;
        tgts[i] <= '0;
        ctrs[i] <= 2'b01;
      end
      br_cnt <= '0;
      mp_cnt <= '0;
    end else begin
      if (upd && ex_hit) begin
        ctrs[ex_idx] <= bp.ex_taken ? ((ctrs[ex_idx] == 2'b11) ? 2'b11 : ctrs[ex_idx] + 2'b01)
                                    : ((ctrs[ex_idx] == 2'b00) ? 2'b00 : ctrs[ex_idx] - 2'b01);
        if (bp.ex_taken) tgts[ex_idx] <= bp.ex_target;
      end else if (upd && bp.ex_taken) begin
        valid[ex_idx] <= 1'b1;
        tags[ex_idx] <= ex_tag;
        tgts[ex_idx] <= bp.ex_target;
        ctrs[ex_idx] <= 2'b10;
      end else if (bp.ex_valid && !bp.ex_is_branch && bp.ex_pred_taken && ex_hit) begin
        // a non-branch predicted taken means this entry belongs to an aliasing PC
        valid[ex_idx] <= 1'b0;
      end
      if (upd && br_cnt != '1) br_cnt <= br_cnt + 1'b1;
      if (misp && mp_cnt != '1) mp_cnt <= mp_cnt + 1'b1;
    end
endmodule
